// File: rtl/vid_frame_select.sv
// Frame-aligned 2:1 selector for AXI video streams.
// Source 0 and source 1 compete for one registered AXI-stream output. Ownership
// only changes on frame boundaries, so the sink never sees a spliced frame.
// With OPT_TUSER_IS_SOF=1, TUSER marks start of frame; otherwise TLAST marks
// end of frame. The unselected source is drained or stalled per OPT_DRAIN_IDLE.
module vid_frame_select #(
   parameter int PW               = 24,
   parameter bit OPT_TUSER_IS_SOF = 1'b1,
   parameter bit OPT_DRAIN_IDLE   = 1'b1
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_sel,
   input  logic          S0_VID_VALID,
   output logic          S0_VID_READY,
   input  logic [PW-1:0] S0_VID_DATA,
   input  logic          S0_VID_LAST,
   input  logic          S0_VID_USER,
   input  logic          S1_VID_VALID,
   output logic          S1_VID_READY,
   input  logic [PW-1:0] S1_VID_DATA,
   input  logic          S1_VID_LAST,
   input  logic          S1_VID_USER,
   output logic          M_VID_VALID,
   input  logic          M_VID_READY,
   output logic [PW-1:0] M_VID_DATA,
   output logic          M_VID_LAST,
   output logic          M_VID_USER,
   output logic          o_src,
   output logic          o_sync
);

   typedef enum logic {
      SYNC = 1'b0,
      PASS = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic          src_q, src_d;
   logic          mValid_q;
   logic [PW-1:0] mData_q;
   logic          mLast_q;
   logic          mUser_q;

   logic          actValid;
   logic [PW-1:0] actData;
   logic          actLast;
   logic          actUser;
   logic          outFree;
   logic          actReady;
   logic          loadOut;

   // The output register can take a new beat when empty or being emptied
   assign outFree = !mValid_q || M_VID_READY;

   // Steer the currently owning source onto a common beat path
   always_comb begin
      if (src_q) begin
         actValid = S1_VID_VALID;
         actData  = S1_VID_DATA;
         actLast  = S1_VID_LAST;
         actUser  = S1_VID_USER;
      end else begin
         actValid = S0_VID_VALID;
         actData  = S0_VID_DATA;
         actLast  = S0_VID_LAST;
         actUser  = S0_VID_USER;
      end
   end

   // Decide the owner's READY, whether a beat enters the output register and
   // when ownership moves; switches only happen on frame boundaries
   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      actReady = 1'b0;
      loadOut  = 1'b0;
      case (state_q)
         SYNC: begin
            if (i_sel != src_q) begin
               src_d    = i_sel;
               actReady = OPT_DRAIN_IDLE;
            end else if (OPT_TUSER_IS_SOF) begin
               if (actValid && actUser) begin
                  state_d = PASS;
               end else begin
                  actReady = 1'b1;
               end
            end else begin
               actReady = 1'b1;
               if (actValid && actLast) begin
                  state_d = PASS;
               end
            end
         end
         PASS: begin
            if (OPT_TUSER_IS_SOF && (i_sel != src_q) && actValid && actUser) begin
               src_d   = i_sel;
               state_d = SYNC;
            end else begin
               actReady = outFree;
               loadOut  = actValid && outFree;
               if (!OPT_TUSER_IS_SOF && loadOut && actLast && (i_sel != src_q)) begin
                  src_d   = i_sel;
                  state_d = SYNC;
               end
            end
         end
         default: begin
            state_d = SYNC;
         end
      endcase
   end

   // The owner gets the decoded READY; the other source is drained or stalled
   assign S0_VID_READY = src_q ? OPT_DRAIN_IDLE : actReady;
   assign S1_VID_READY = src_q ? actReady : OPT_DRAIN_IDLE;

   // State, ownership and the output register; data holds while stalled
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= SYNC;
         src_q    <= 1'b0;
         mValid_q <= 1'b0;
         mData_q  <= '0;
         mLast_q  <= 1'b0;
         mUser_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         if (outFree) begin
            mValid_q <= loadOut;
            if (loadOut) begin
               mData_q <= actData;
               mLast_q <= actLast;
               mUser_q <= actUser;
            end
         end
      end
   end

   assign M_VID_VALID = mValid_q;
   assign M_VID_DATA  = mData_q;
   assign M_VID_LAST  = mLast_q;
   assign M_VID_USER  = mUser_q;
   assign o_src       = src_q;
   assign o_sync      = (state_q == SYNC);

endmodule

// File: tb/tb_vid_frame_select.sv
// Testbench for vid_frame_select.
// Instance 0 runs start-of-frame framing with idle draining, instance 1 runs
// end-of-frame framing with idle stalling. Directed tables pin down cycle-level
// behaviour; a randomized run checks whole-frame delivery against frame rules.
module tb_vid_frame_select;

   localparam int PW     = 24;
   localparam int HOLD   = 400;
   localparam int SETTLE = 250;
   localparam int RUN    = 3200;
   localparam int RSTCYC = 1700;

   typedef struct {
      logic          sel;
      logic          v0;
      logic          u0;
      logic          l0;
      logic          v1;
      logic          u1;
      logic          l1;
      logic          mr;
      logic          expR0;
      logic          expR1;
      logic          expV;
      logic          expU;
      logic          expL;
      logic [PW-1:0] expD;
      logic          expSrc;
      logic          expSync;
   } vec_t;

   logic          clock = 1'b0;
   logic          reset;
   logic          sel    [2];
   logic          sValid [2][2];
   logic          sReady [2][2];
   logic [PW-1:0] sData  [2][2];
   logic          sLast  [2][2];
   logic          sUser  [2][2];
   logic          mValid [2];
   logic          mReady [2];
   logic [PW-1:0] mData  [2];
   logic          mLast  [2];
   logic          mUser  [2];
   logic          oSrc   [2];
   logic          oSync  [2];

   int errors = 0;
   int checks = 0;

   vec_t tabA [16];
   vec_t tabB [10];

   int            pix         [2][2];
   int            frm         [2][2];
   logic          acc         [2][2];
   logic          stalled     [2];
   logic [PW-1:0] hData       [2];
   logic          hLast       [2];
   logic          hUser       [2];
   logic          expectStart [2];
   logic          havePrev    [2];
   int            prevSrc     [2];
   int            prevFrm     [2];
   int            prevStart   [2];
   logic [PW-1:0] lastBeat    [2];
   int            lastChange  [2];
   int            frames      [2];

   // Free-running clock
   always #5 clock = ~clock;

   vid_frame_select #(.PW(PW), .OPT_TUSER_IS_SOF(1'b1), .OPT_DRAIN_IDLE(1'b1)) dutA (
      .i_clk(clock), .i_reset(reset), .i_sel(sel[0]),
      .S0_VID_VALID(sValid[0][0]), .S0_VID_READY(sReady[0][0]), .S0_VID_DATA(sData[0][0]),
      .S0_VID_LAST(sLast[0][0]), .S0_VID_USER(sUser[0][0]),
      .S1_VID_VALID(sValid[0][1]), .S1_VID_READY(sReady[0][1]), .S1_VID_DATA(sData[0][1]),
      .S1_VID_LAST(sLast[0][1]), .S1_VID_USER(sUser[0][1]),
      .M_VID_VALID(mValid[0]), .M_VID_READY(mReady[0]), .M_VID_DATA(mData[0]),
      .M_VID_LAST(mLast[0]), .M_VID_USER(mUser[0]),
      .o_src(oSrc[0]), .o_sync(oSync[0])
   );

   vid_frame_select #(.PW(PW), .OPT_TUSER_IS_SOF(1'b0), .OPT_DRAIN_IDLE(1'b0)) dutB (
      .i_clk(clock), .i_reset(reset), .i_sel(sel[1]),
      .S0_VID_VALID(sValid[1][0]), .S0_VID_READY(sReady[1][0]), .S0_VID_DATA(sData[1][0]),
      .S0_VID_LAST(sLast[1][0]), .S0_VID_USER(sUser[1][0]),
      .S1_VID_VALID(sValid[1][1]), .S1_VID_READY(sReady[1][1]), .S1_VID_DATA(sData[1][1]),
      .S1_VID_LAST(sLast[1][1]), .S1_VID_USER(sUser[1][1]),
      .M_VID_VALID(mValid[1]), .M_VID_READY(mReady[1]), .M_VID_DATA(mData[1]),
      .M_VID_LAST(mLast[1]), .M_VID_USER(mUser[1]),
      .o_src(oSrc[1]), .o_sync(oSync[1])
   );

   // ins = {sel v0 u0 l0 v1 u1 l1 mready}, exps = {s0ready s1ready mvalid muser mlast}
   function automatic vec_t mk(input logic [7:0] ins, input logic [4:0] exps,
                               input logic [PW-1:0] ed, input logic es, input logic ey);
      vec_t v;
      v.sel = ins[7]; v.v0 = ins[6]; v.u0 = ins[5]; v.l0 = ins[4];
      v.v1 = ins[3]; v.u1 = ins[2]; v.l1 = ins[1]; v.mr = ins[0];
      v.expR0 = exps[4]; v.expR1 = exps[3]; v.expV = exps[2]; v.expU = exps[1]; v.expL = exps[0];
      v.expD = ed; v.expSrc = es; v.expSync = ey;
      return v;
   endfunction

   function automatic logic [PW-1:0] encode(input int s, input int f, input int p);
      return {s[3:0], f[11:0], p[7:0]};
   endfunction

   // Instance 0 frames: TUSER on pixel 0, TLAST at each line end
   // Instance 1 frames: TUSER at each line end, TLAST on pixel 11
   function automatic logic isUser(input int d, input int p);
      return (d == 0) ? (p == 0) : (p % 4 == 3);
   endfunction

   function automatic logic isLast(input int d, input int p);
      return (d == 0) ? (p % 4 == 3) : (p == 11);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int d, input int idx, input vec_t v);
      @(negedge clock);
      sel[d]       = v.sel;
      sValid[d][0] = v.v0; sUser[d][0] = v.u0; sLast[d][0] = v.l0;
      sData[d][0]  = 24'hA00000 + 24'(idx);
      sValid[d][1] = v.v1; sUser[d][1] = v.u1; sLast[d][1] = v.l1;
      sData[d][1]  = 24'hB00000 + 24'(idx);
      mReady[d]    = v.mr;
   endtask

   task automatic runRow(input int d, input string tag, input int idx, input vec_t v);
      applyStimulus(d, idx, v);
      #1;
      checkOutput($sformatf("%s%0d s0ready", tag, idx), sReady[d][0], v.expR0);
      checkOutput($sformatf("%s%0d s1ready", tag, idx), sReady[d][1], v.expR1);
      @(posedge clock);
      #1;
      checkOutput($sformatf("%s%0d mvalid", tag, idx), mValid[d], v.expV);
      checkOutput($sformatf("%s%0d src", tag, idx), oSrc[d], v.expSrc);
      checkOutput($sformatf("%s%0d sync", tag, idx), oSync[d], v.expSync);
      if (v.expV) begin
         checkOutput($sformatf("%s%0d mdata", tag, idx), mData[d], v.expD);
         checkOutput($sformatf("%s%0d muser", tag, idx), mUser[d], v.expU);
         checkOutput($sformatf("%s%0d mlast", tag, idx), mLast[d], v.expL);
      end
   endtask

   task automatic pulseReset();
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   // Every output beat must extend a whole, in-order frame from one source
   task automatic checkBeat(input int d, input int cyc);
      int p;
      int f;
      int s;
      p = int'(mData[d][7:0]);
      f = int'(mData[d][19:8]);
      s = int'(mData[d][23:20]);
      if (expectStart[d]) begin
         checkOutput($sformatf("D%0d frame start pixel", d), p, 0);
         if (cyc - lastChange[d] > SETTLE)
            checkOutput($sformatf("D%0d frame source", d), s, sel[d]);
         if (havePrev[d] && s == prevSrc[d] && lastChange[d] < prevStart[d])
            checkOutput($sformatf("D%0d frame sequence", d), f, prevFrm[d] + 1);
         havePrev[d]  = 1'b1;
         prevSrc[d]   = s;
         prevFrm[d]   = f;
         prevStart[d] = cyc;
         frames[d]++;
      end else begin
         checkOutput($sformatf("D%0d pixel order", d), mData[d], lastBeat[d] + 24'd1);
      end
      checkOutput($sformatf("D%0d tuser", d), mUser[d], isUser(d, p));
      checkOutput($sformatf("D%0d tlast", d), mLast[d], isLast(d, p));
      lastBeat[d]    = mData[d];
      expectStart[d] = (p == 11);
   endtask

   // Directed tables, then randomized frame traffic with backpressure
   initial begin
      reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         sel[d] = 1'b0; mReady[d] = 1'b0;
         for (int s = 0; s < 2; s++) begin
            sValid[d][s] = 1'b0; sData[d][s] = '0; sLast[d][s] = 1'b0; sUser[d][s] = 1'b0;
         end
      end

      tabA[0]  = mk(8'b0_100_000_1, 5'b11_000, 24'h0,      1'b0, 1'b1);
      tabA[1]  = mk(8'b0_101_000_1, 5'b11_000, 24'h0,      1'b0, 1'b1);
      tabA[2]  = mk(8'b0_110_000_1, 5'b01_000, 24'h0,      1'b0, 1'b0);
      tabA[3]  = mk(8'b0_110_000_1, 5'b11_110, 24'hA00003, 1'b0, 1'b0);
      tabA[4]  = mk(8'b1_100_000_1, 5'b11_100, 24'hA00004, 1'b0, 1'b0);
      tabA[5]  = mk(8'b0_100_000_1, 5'b11_100, 24'hA00005, 1'b0, 1'b0);
      tabA[6]  = mk(8'b1_110_000_1, 5'b01_000, 24'h0,      1'b1, 1'b1);
      tabA[7]  = mk(8'b1_000_100_1, 5'b11_000, 24'h0,      1'b1, 1'b1);
      tabA[8]  = mk(8'b1_000_110_1, 5'b10_000, 24'h0,      1'b1, 1'b0);
      tabA[9]  = mk(8'b1_000_110_1, 5'b11_110, 24'hB00009, 1'b1, 1'b0);
      tabA[10] = mk(8'b1_000_100_0, 5'b10_110, 24'hB00009, 1'b1, 1'b0);
      tabA[11] = mk(8'b1_000_101_1, 5'b11_101, 24'hB0000B, 1'b1, 1'b0);
      tabA[12] = mk(8'b1_000_000_1, 5'b11_000, 24'h0,      1'b1, 1'b0);
      tabA[13] = mk(8'b0_000_110_1, 5'b10_000, 24'h0,      1'b0, 1'b1);
      tabA[14] = mk(8'b1_110_000_1, 5'b11_000, 24'h0,      1'b1, 1'b1);
      tabA[15] = mk(8'b1_000_110_1, 5'b10_000, 24'h0,      1'b1, 1'b0);

      tabB[0]  = mk(8'b0_100_000_1, 5'b10_000, 24'h0,      1'b0, 1'b1);
      tabB[1]  = mk(8'b0_101_000_1, 5'b10_000, 24'h0,      1'b0, 1'b0);
      tabB[2]  = mk(8'b0_100_000_1, 5'b10_100, 24'hA00002, 1'b0, 1'b0);
      tabB[3]  = mk(8'b1_100_000_1, 5'b10_100, 24'hA00003, 1'b0, 1'b0);
      tabB[4]  = mk(8'b1_101_000_0, 5'b00_100, 24'hA00003, 1'b0, 1'b0);
      tabB[5]  = mk(8'b1_101_000_1, 5'b10_101, 24'hA00005, 1'b1, 1'b1);
      tabB[6]  = mk(8'b1_000_100_1, 5'b01_000, 24'h0,      1'b1, 1'b1);
      tabB[7]  = mk(8'b1_000_101_1, 5'b01_000, 24'h0,      1'b1, 1'b0);
      tabB[8]  = mk(8'b1_000_100_1, 5'b01_100, 24'hB00008, 1'b1, 1'b0);
      tabB[9]  = mk(8'b0_000_000_1, 5'b01_000, 24'h0,      1'b1, 1'b0);

      repeat (2) @(posedge clock);
      #1;
      for (int d = 0; d < 2; d++) begin
         checkOutput($sformatf("D%0d reset mvalid", d), mValid[d], 1'b0);
         checkOutput($sformatf("D%0d reset src", d), oSrc[d], 1'b0);
         checkOutput($sformatf("D%0d reset sync", d), oSync[d], 1'b1);
      end
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) runRow(0, "A", i, tabA[i]);
      for (int i = 0; i < 10; i++) runRow(1, "B", i, tabB[i]);

      for (int d = 0; d < 2; d++) begin
         sel[d] = 1'b0;
         for (int s = 0; s < 2; s++) begin
            sValid[d][s] = 1'b0;
            acc[d][s]    = 1'b0;
            pix[d][s]    = $urandom_range(11);
            frm[d][s]    = 0;
         end
         stalled[d] = 1'b0; expectStart[d] = 1'b1; havePrev[d] = 1'b0;
         lastChange[d] = 0; frames[d] = 0; prevStart[d] = 0;
         lastBeat[d] = '0; hData[d] = '0; hLast[d] = 1'b0; hUser[d] = 1'b0;
      end
      pulseReset();

      for (int cyc = 0; cyc < RUN; cyc++) begin
         @(negedge clock);
         reset = (cyc == RSTCYC);
         if (cyc % HOLD == HOLD - 1) begin
            for (int d = 0; d < 2; d++) begin
               sel[d] = ~sel[d];
               lastChange[d] = cyc;
            end
         end
         for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 2; s++) begin
               if (acc[d][s]) begin
                  pix[d][s]++;
                  if (pix[d][s] == 12) begin
                     pix[d][s] = 0;
                     frm[d][s]++;
                  end
               end
               if (!sValid[d][s] || acc[d][s]) begin
                  sValid[d][s] = ($urandom_range(3) != 0);
                  sData[d][s]  = encode(s, frm[d][s], pix[d][s]);
                  sUser[d][s]  = isUser(d, pix[d][s]);
                  sLast[d][s]  = isLast(d, pix[d][s]);
               end
            end
            mReady[d] = ($urandom_range(3) != 0);
         end
         #1;
         for (int d = 0; d < 2; d++) begin
            if (stalled[d]) begin
               checkOutput($sformatf("D%0d stall valid", d), mValid[d], 1'b1);
               checkOutput($sformatf("D%0d stall data", d), mData[d], hData[d]);
               checkOutput($sformatf("D%0d stall last", d), mLast[d], hLast[d]);
               checkOutput($sformatf("D%0d stall user", d), mUser[d], hUser[d]);
            end
            for (int s = 0; s < 2; s++) acc[d][s] = sValid[d][s] && sReady[d][s];
            if (cyc - lastChange[d] == 300)
               checkOutput($sformatf("D%0d owner after switch", d), oSrc[d], sel[d]);
            if (mValid[d] && mReady[d]) checkBeat(d, cyc);
            stalled[d] = mValid[d] && !mReady[d];
            hData[d] = mData[d]; hLast[d] = mLast[d]; hUser[d] = mUser[d];
         end
         @(posedge clock);
         if (reset) begin
            #1;
            for (int d = 0; d < 2; d++) begin
               checkOutput($sformatf("D%0d midframe reset mvalid", d), mValid[d], 1'b0);
               checkOutput($sformatf("D%0d midframe reset src", d), oSrc[d], 1'b0);
               checkOutput($sformatf("D%0d midframe reset sync", d), oSync[d], 1'b1);
               stalled[d] = 1'b0; expectStart[d] = 1'b1; havePrev[d] = 1'b0;
               lastChange[d] = cyc;
            end
         end
      end

      checkOutput("D0 frames delivered", frames[0] >= 40, 1'b1);
      checkOutput("D1 frames delivered", frames[1] >= 40, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
